// File: rtl/fwpayload_gpio_wb.sv
// Wishbone GPIO target: N_PINS outputs with enables, atomic set/clear/toggle,
// synchronised inputs and per-pin edge interrupts with W1C status.
module fwpayload_gpio_wb #(
    parameter int N_PINS      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADR_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADR_WIDTH-1:0] t_adr,
    input  logic [31:0]          t_dat_w,
    output logic [31:0]          t_dat_r,
    input  logic                 t_cyc,
    input  logic                 t_stb,
    input  logic                 t_we,
    input  logic [3:0]           t_sel,
    output logic                 t_ack,
    output logic                 t_err,
    input  logic [N_PINS-1:0]    gpio_in,
    output logic [N_PINS-1:0]    gpio_out,
    output logic [N_PINS-1:0]    gpio_oe,
    output logic                 irq
);
    localparam logic [3:0] REG_OUT  = 4'h0;
    localparam logic [3:0] REG_OE   = 4'h1;
    localparam logic [3:0] REG_IN   = 4'h2;
    localparam logic [3:0] REG_SET  = 4'h3;
    localparam logic [3:0] REG_CLR  = 4'h4;
    localparam logic [3:0] REG_TGL  = 4'h5;
    localparam logic [3:0] REG_RISE = 4'h6;
    localparam logic [3:0] REG_FALL = 4'h7;
    localparam logic [3:0] REG_STAT = 4'h8;

    logic [N_PINS-1:0] out_q, oe_q, rise_en, fall_en, irq_stat;
    logic [N_PINS-1:0] sync_q [SYNC_STAGES];
    logic [N_PINS-1:0] sync_in, sync_d, set_ev, w1c, wd, msk;
    logic [31:0]       lane_mask, wd_full, rdata;
    logic [3:0]        reg_sel;
    logic              req, unused;

    // Valid/ready: a request is cyc&stb; ack is a one-cycle pulse the edge after,
    // and the ~t_ack term forces a gap so a held strobe acks every other cycle.
    assign req       = t_cyc & t_stb & ~t_ack;
    assign reg_sel   = t_adr[5:2];
    assign lane_mask = {{8{t_sel[3]}}, {8{t_sel[2]}}, {8{t_sel[1]}}, {8{t_sel[0]}}};
    assign wd_full   = t_dat_w & lane_mask;
    assign wd        = wd_full[N_PINS-1:0];
    assign msk       = lane_mask[N_PINS-1:0];
    assign unused    = ^{t_adr, wd_full, lane_mask};

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign set_ev  = (sync_in & ~sync_d & rise_en) | (~sync_in & sync_d & fall_en);
    assign w1c     = (req && t_we && reg_sel == REG_STAT) ? wd : '0;

    assign t_err    = 1'b0;
    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_OUT:  rdata[N_PINS-1:0] = out_q;
            REG_OE:   rdata[N_PINS-1:0] = oe_q;
            REG_IN:   rdata[N_PINS-1:0] = sync_in;
            REG_RISE: rdata[N_PINS-1:0] = rise_en;
            REG_FALL: rdata[N_PINS-1:0] = fall_en;
            REG_STAT: rdata[N_PINS-1:0] = irq_stat;
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sync_d <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_d <= sync_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            t_ack    <= 1'b0;
            t_dat_r  <= '0;
            irq      <= 1'b0;
            irq_stat <= '0;
            out_q    <= '0;
            oe_q     <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else begin
            t_ack    <= req;
            t_dat_r  <= (req && !t_we) ? rdata : '0;
            irq      <= |irq_stat;
            // A fresh edge beats a simultaneous W1C of the same bit.
            irq_stat <= (irq_stat & ~w1c) | set_ev;
            if (req && t_we) begin
                case (reg_sel)
                    REG_OUT:  out_q   <= (out_q & ~msk) | wd;
                    REG_OE:   oe_q    <= (oe_q & ~msk) | wd;
                    REG_SET:  out_q   <= out_q | wd;
                    REG_CLR:  out_q   <= out_q & ~wd;
                    REG_TGL:  out_q   <= out_q ^ wd;
                    REG_RISE: rise_en <= (rise_en & ~msk) | wd;
                    REG_FALL: fall_en <= (fall_en & ~msk) | wd;
                    default: ;
                endcase
            end
        end
    end
endmodule
